// File: rtl/cell_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : cell_dispatcher
// Brief    : Command front end for CellProcessor. Issues operations, tracks them
//            through the fixed-latency pipeline, buffers results in an in-order
//            FIFO and supports a flush handshake.
//            Optional statistics counters: define CELL_DISPATCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cell_dispatcher #(
    parameter int CELL_W   = 24,
    parameter int USER_W   = 8,
    parameter int OPC_W    = 4,
    parameter int PROC_LAT = 1,
    parameter int DEPTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CELL_W-1:0] cmd_cellA,
    input  logic [CELL_W-1:0] cmd_cellB,
    input  logic [USER_W-1:0] cmd_user,
    input  logic [OPC_W-1:0]  cmd_opcode,
    output logic [CELL_W-1:0] proc_cellA,
    output logic [CELL_W-1:0] proc_cellB,
    output logic [USER_W-1:0] proc_user,
    output logic [OPC_W-1:0]  proc_opcode,
    input  logic [CELL_W-1:0] proc_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CELL_W-1:0] res_cell,
    input  logic              flush_req,
    output logic              flush_done,
`ifdef CELL_DISPATCH_STATS_EN
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_completed,
`endif
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    // Wide enough for inflight + fifo_cnt without overflow.
    localparam int CNT_W = $clog2(DEPTH + PROC_LAT + 2);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PROC_LAT:0] trk_q, trk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  infl_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CELL_W-1:0] mem_q [DEPTH];

    logic              cmd_ready_q;
    logic              res_valid_q;
    logic              flush_done_q;
    logic              busy_q;
    logic [CELL_W-1:0] proc_cellA_q;
    logic [CELL_W-1:0] proc_cellB_q;
    logic [USER_W-1:0] proc_user_q;
    logic [OPC_W-1:0]  proc_opcode_q;

    logic w_accept;
    logic w_pop;
    logic w_push;
    logic w_full;
    logic w_wr;

    assign w_accept = cmd_valid && cmd_ready_q;
    assign w_pop    = res_valid_q && res_ready;
    assign w_push   = trk_q[PROC_LAT];
    assign w_full   = (cnt_q == C_DEPTH);
    assign w_wr     = w_push && !w_full;

    always_comb begin
        trk_d   = {trk_q[PROC_LAT-1:0], w_accept};
        infl_d  = '0;
        for (int i = 0; i <= PROC_LAT; i++) begin
            infl_d = infl_d + CNT_W'(trk_d[i]);
        end
        cnt_d   = cnt_q + CNT_W'(w_wr) - CNT_W'(w_pop);
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req) state_d = DRAIN;
            // Looking at next-cycle counts lets DONE follow the final pop directly.
            DRAIN:   if (infl_d == '0 && cnt_d == '0) state_d = DONE;
            DONE:    state_d = flush_req ? DRAIN : RUN;
            default: state_d = RUN;
        endcase
    end

    // Handshake/status outputs are registered from next-state values so they
    // carry no combinational path from any input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            trk_q         <= '0;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cmd_ready_q   <= 1'b1;
            res_valid_q   <= 1'b0;
            flush_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            proc_cellA_q  <= '0;
            proc_cellB_q  <= '0;
            proc_user_q   <= '0;
            proc_opcode_q <= '0;
        end else begin
            state_q      <= state_d;
            trk_q        <= trk_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= (state_d == RUN) && ((infl_d + cnt_d) < C_DEPTH);
            res_valid_q  <= (cnt_d != '0);
            flush_done_q <= (state_d == DONE);
            busy_q       <= (infl_d != '0) || (cnt_d != '0);
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (w_accept) begin
                proc_cellA_q  <= cmd_cellA;
                proc_cellB_q  <= cmd_cellB;
                proc_user_q   <= cmd_user;
                proc_opcode_q <= cmd_opcode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= proc_result;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

`ifdef CELL_DISPATCH_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_completed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q    <= '0;
            stat_completed_q <= '0;
        end else begin
            if (w_accept && (stat_issued_q != 32'hFFFF_FFFF)) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if (w_pop && (stat_completed_q != 32'hFFFF_FFFF)) begin
                stat_completed_q <= stat_completed_q + 32'd1;
            end
        end
    end

    assign stat_issued    = stat_issued_q;
    assign stat_completed = stat_completed_q;
`endif

    assign cmd_ready   = cmd_ready_q;
    assign res_valid   = res_valid_q;
    assign res_cell    = mem_q[rd_ptr_q];
    assign flush_done  = flush_done_q;
    assign busy        = busy_q;
    assign proc_cellA  = proc_cellA_q;
    assign proc_cellB  = proc_cellB_q;
    assign proc_user   = proc_user_q;
    assign proc_opcode = proc_opcode_q;

endmodule
`default_nettype wire

// File: tb/tb_cell_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_dispatcher
// Brief    : Directed self-checking bench for cell_dispatcher with an A+B
//            single-cycle processor model (PROC_LAT=1, DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_dispatcher;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_cellA;
    logic [23:0] cmd_cellB;
    logic [7:0]  cmd_user;
    logic [3:0]  cmd_opcode;
    logic [23:0] proc_cellA;
    logic [23:0] proc_cellB;
    logic [7:0]  proc_user;
    logic [3:0]  proc_opcode;
    logic [23:0] proc_result;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_cell;
    logic        flush_req;
    logic        flush_done;
    logic        busy;
`ifdef CELL_DISPATCH_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_completed;
`endif

    int checks = 0;
    int errors = 0;

    cell_dispatcher #(
        .CELL_W   (24),
        .USER_W   (8),
        .OPC_W    (4),
        .PROC_LAT (1),
        .DEPTH    (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_cellA      (cmd_cellA),
        .cmd_cellB      (cmd_cellB),
        .cmd_user       (cmd_user),
        .cmd_opcode     (cmd_opcode),
        .proc_cellA     (proc_cellA),
        .proc_cellB     (proc_cellB),
        .proc_user      (proc_user),
        .proc_opcode    (proc_opcode),
        .proc_result    (proc_result),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_cell       (res_cell),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
`ifdef CELL_DISPATCH_STATS_EN
        .stat_issued    (stat_issued),
        .stat_completed (stat_completed),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Processor stand-in: one registered stage computing A+B.
    initial proc_result = '0;
    always @(posedge clk) proc_result <= proc_cellA + proc_cellB;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        int          issued;
        int          got;
        int          stalls;
        int          cyc;
        int          pops;
        int          pulses;
        int          pulse_j;
        logic [23:0] exp_q[$];
        logic [23:0] e;

        rst = 1'b1; cmd_valid = 1'b0; cmd_cellA = '0; cmd_cellB = '0;
        cmd_user = '0; cmd_opcode = '0; res_ready = 1'b0; flush_req = 1'b0;
        step; step;
        rst = 1'b0;

        // ---- reset state ----
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_proc_cellA", proc_cellA, 0);
        chk("rst_proc_opcode", proc_opcode, 0);
`ifdef CELL_DISPATCH_STATS_EN
        chk("rst_stat_issued", stat_issued, 0);
        chk("rst_stat_completed", stat_completed, 0);
`endif

        // ---- single operation ----
        cmd_valid = 1'b1; cmd_cellA = 24'h000010; cmd_cellB = 24'h000020;
        cmd_user = 8'h5A; cmd_opcode = 4'h3;
        step;
        cmd_valid = 1'b0;
        chk("single_proc_cellA", proc_cellA, 24'h000010);
        chk("single_proc_cellB", proc_cellB, 24'h000020);
        chk("single_proc_user", proc_user, 8'h5A);
        chk("single_proc_opcode", proc_opcode, 4'h3);
        chk("single_busy_c1", busy, 1);
        chk("single_res_valid_c1", res_valid, 0);
        step;
        chk("single_res_valid_c2", res_valid, 0);
        step;
        chk("single_res_valid_c3", res_valid, 1);
        chk("single_res_cell", res_cell, 24'h000030);
        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        chk("single_res_valid_c4", res_valid, 0);
        chk("single_busy_c4", busy, 0);
        chk("single_proc_hold", proc_cellA, 24'h000010);

        // ---- back-pressure: exactly DEPTH accepts ----
        acc = 0;
        cmd_valid = 1'b1; cmd_cellB = 24'h000001;
        for (int k = 0; k < 14; k++) begin
            cmd_cellA = 24'h001000 + 24'(acc);
            if (cmd_ready) acc++;
            step;
        end
        cmd_valid = 1'b0;
        chk("bp_accepts", acc, 8);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("bp_res_valid_k", res_valid, 1);
            chk("bp_res_cell", res_cell, 24'h001001 + 24'(k));
            if (k == 0) chk("bp_ready_before_pop", cmd_ready, 0);
            if (k == 1) chk("bp_ready_after_pop", cmd_ready, 1);
            step;
        end
        res_ready = 1'b0;
        chk("bp_empty", res_valid, 0);
        chk("bp_busy", busy, 0);

        // ---- streaming 100 commands ----
        issued = 0; got = 0; stalls = 0; cyc = 0;
        res_ready = 1'b1;
        while (got < 100 && cyc < 400) begin
            cmd_valid = (issued < 100);
            cmd_cellA = 24'(issued * 66051);
            cmd_cellB = 24'h0F0000 + 24'(issued);
            if (cmd_valid) begin
                if (cmd_ready) begin
                    exp_q.push_back(cmd_cellA + cmd_cellB);
                    issued++;
                end else begin
                    stalls++;
                end
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious", res_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_res", res_cell, e);
                end
                got++;
            end
            step;
            cyc++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        chk("stream_issued", issued, 100);
        chk("stream_got", got, 100);
        chk("stream_stalls", stalls, 0);

        // ---- flush with 3 in flight, res_ready toggling ----
        cmd_valid = 1'b1; cmd_cellB = 24'h000000;
        for (int k = 0; k < 3; k++) begin
            cmd_cellA = 24'h000200 + 24'(k);
            if (k == 2) flush_req = 1'b1;
            chk("flush_accept", cmd_ready, 1);
            step;
        end
        cmd_valid = 1'b0;
        pops = 0; pulses = 0; pulse_j = -1;
        for (int j = 0; j < 7; j++) begin
            res_ready = ((j % 2) == 0);
            if (j <= 5) chk("flush_ready_low", cmd_ready, 0);
            else        chk("flush_ready_back", cmd_ready, 1);
            if (res_valid && res_ready) begin
                chk("flush_res", res_cell, 24'h000200 + 24'(pops));
                pops++;
            end
            if (flush_done) begin
                pulses++;
                pulse_j = j;
                flush_req = 1'b0;
            end
            step;
        end
        res_ready = 1'b0;
        chk("flush_pops", pops, 3);
        chk("flush_pulses", pulses, 1);
        chk("flush_pulse_cycle", pulse_j, 5);

        // ---- idle flush, held request repeats every 2 cycles ----
        flush_req = 1'b1;
        chk("idle_fd_f0", flush_done, 0);
        step;
        chk("idle_fd_f1", flush_done, 0);
        step;
        chk("idle_fd_f2", flush_done, 1);
        step;
        chk("idle_fd_f3", flush_done, 0);
        step;
        chk("idle_fd_f4", flush_done, 1);
        flush_req = 1'b0;
        step;
        chk("idle_fd_f5", flush_done, 0);
        chk("idle_ready_f5", cmd_ready, 1);

        // ---- reset mid-stream with 4 outstanding ----
        cmd_valid = 1'b1; cmd_cellB = 24'h000000;
        for (int k = 0; k < 4; k++) begin
            cmd_cellA = 24'h000300 + 24'(k);
            step;
        end
        cmd_valid = 1'b0;
        chk("mid_busy", busy, 1);
        chk("mid_res_valid", res_valid, 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_flush_done", flush_done, 0);
        chk("mid_rst_proc_cellA", proc_cellA, 0);
        chk("mid_rst_proc_cellB", proc_cellB, 0);
        for (int k = 0; k < 3; k++) begin
            step;
            chk("mid_no_stale", res_valid, 0);
        end

        // ---- 5 accepts, 3 pops, then drain ----
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_cellA = 24'h000400 + 24'(k);
            cmd_cellB = 24'(k);
            chk("five_accept", cmd_ready, 1);
            step;
        end
        cmd_valid = 1'b0;
        step; step;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("five_res", res_cell, 24'h000400 + 24'(2 * k));
            step;
        end
        res_ready = 1'b0;
`ifdef CELL_DISPATCH_STATS_EN
        chk("stat_issued_5", stat_issued, 5);
        chk("stat_completed_3", stat_completed, 3);
`endif
        res_ready = 1'b1;
        for (int k = 3; k < 5; k++) begin
            chk("five_res_tail", res_cell, 24'h000400 + 24'(2 * k));
            step;
        end
        res_ready = 1'b0;
        chk("five_busy", busy, 0);
`ifdef CELL_DISPATCH_STATS_EN
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("stat_issued_rst", stat_issued, 0);
        chk("stat_completed_rst", stat_completed, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
